// File: rtl/req_issue_rob.sv
// Issue stage and reorder buffer in front of execution_unit.
// Commands are tagged with IDs 1..7 in round-robin order, responses may
// return in any order, and results are handed back to the host in issue order.

package req_issue_rob_pkg;

  typedef struct packed {
    logic        req;
    logic        req_type;
    logic [2:0]  req_id;
    logic [31:0] req_data1;
    logic [31:0] req_data2;
  } req_pkt_type;

  typedef struct packed {
    logic        rsp;
    logic [2:0]  rsp_id;
    logic [63:0] rsp_data;
  } rsp_pkt_type;

endpackage

module req_issue_rob
  import req_issue_rob_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 7
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_type,
  input  logic [31:0] cmd_data1,
  input  logic [31:0] cmd_data2,
  output req_pkt_type exe_req,
  input  logic        exe_fifo_full,
  input  rsp_pkt_type exe_rsp,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  res_id,
  output logic [63:0] res_data,
  output logic [2:0]  outstanding,
  output logic        err_unexp
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  // Index 0 of the entry arrays is never allocated; it stays idle so that
  // a response carrying ID 0 always looks like a non-busy entry.
  logic [7:0]  busy;
  logic [7:0]  done;
  logic [63:0] data [8];
  logic [2:0]  head;
  logic [2:0]  tail;
  logic [2:0]  count;

  logic issue;
  logic retire;
  logic rsp_hit;
  logic rsp_drop;

  // IDs walk 1..7 and wrap back to 1, skipping 0.
  function automatic logic [2:0] next_id(input logic [2:0] id);
    return (id == 3'd7) ? 3'd1 : id + 3'd1;
  endfunction

  // Handshakes, request packet and in-order result view; results come only
  // from stored state, so a response to head shows up one cycle later.
  always_comb begin
    cmd_ready = !exe_fifo_full && (count < MAX_CNT);
    issue     = cmd_valid && cmd_ready;
    exe_req   = '0;
    if (issue) begin
      exe_req.req       = 1'b1;
      exe_req.req_type  = cmd_type;
      exe_req.req_id    = tail;
      exe_req.req_data1 = cmd_data1;
      exe_req.req_data2 = cmd_data2;
    end
    res_valid = busy[head] && done[head];
    res_id    = res_valid ? head : 3'd0;
    res_data  = res_valid ? data[head] : 64'd0;
    retire    = res_valid && res_ready;
    rsp_hit   = exe_rsp.rsp && (exe_rsp.rsp_id != 3'd0) &&
                busy[exe_rsp.rsp_id] && !done[exe_rsp.rsp_id];
    rsp_drop  = exe_rsp.rsp && !rsp_hit;
    outstanding = count;
  end

  // Entry flags, pointers, occupancy and the sticky error flag; issue only
  // touches tail and retire only touches head, which never alias while either fires.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      busy      <= '0;
      done      <= '0;
      head      <= 3'd1;
      tail      <= 3'd1;
      count     <= 3'd0;
      err_unexp <= 1'b0;
    end else begin
      if (rsp_hit) begin
        done[exe_rsp.rsp_id] <= 1'b1;
      end
      if (rsp_drop) begin
        err_unexp <= 1'b1;
      end
      if (issue) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= next_id(tail);
      end
      if (retire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= next_id(head);
      end
      case ({issue, retire})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Result payload storage; it is only observed while the entry is done.
  always_ff @(posedge clk) begin
    if (rsp_hit) begin
      data[exe_rsp.rsp_id] <= exe_rsp.rsp_data;
    end
  end

endmodule
